ni_pkt_gen2: RTL and testbench

//  Parametrised GPU<->router network interface. Sits between one GPU port and its leaf router.
//  TX: translates the GPU destination ID in the flit header to a routing address.
//  RX: filters on own address and restores the GPU ID.

---
 rtl/ni_pkt_gen2.sv | 192 +++++++++++++++++++
 tb/tb_ni_pkt_gen2.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_pkt_gen2.sv
// ni_pkt_gen2 - network interface between one GPU port and its leaf router.
//
// TX path: GPU flit -> check the destination GPU ID -> rewrite the header to a
//          routing address -> FIFO -> output register -> router.
// RX path: router flit -> keep it only if its address is ours -> restore the
//          GPU ID -> FIFO -> output register -> GPU.
//
// The two paths share nothing except clock and reset.
//
// Ports
//   clk, reset                               clock (rising edge); async active-high reset
//   gpu_data_in/valid_in,  gpu_ready_out     TX ingress from the GPU
//   router_data_out/valid_out, router_ready_in  TX egress to the router
//   router_data_in/valid_in, router_ready_out   RX ingress from the router
//   gpu_data_out/valid_out, gpu_ready_in     RX egress to the GPU
//   tx_drop_cnt, rx_drop_cnt                 saturating drop counters
//   tx_level, rx_level                       FIFO occupancy (output register excluded)

// One direction: power-of-2 FIFO followed by a hold-under-backpressure
// output register.
module ni_pkt_gen2_chan #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_in_i,
    output logic [LVL_W-1:0]  level_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;
    logic              full, empty, push, pop;

    assign full    = (lvl_q == LVL_W'(FIFO_DEPTH));
    assign empty   = (lvl_q == '0);
    // Ready is computed from the pre-pop level, so a full FIFO never takes
    // a push even when it is popping in the same cycle.
    assign ready_o = !full;
    assign push    = push_i && !full;
    assign pop     = (!vld_q || ready_in_i) && !empty;

    always_comb begin
        lvl_d = lvl_q;
        case ({push, pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            lvl_q  <= '0;
            vld_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
                dout_q <= mem_q[rptr_q];
                vld_q  <= 1'b1;
            end else if (ready_in_i) begin
                // Current flit taken and nothing to replace it.
                vld_q <= 1'b0;
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_data_i;
    end

    assign data_o  = dout_q;
    assign valid_o = vld_q;
    assign level_o = lvl_q;
endmodule

module ni_pkt_gen2 #(
    parameter int GPU_ID      = 22,
    parameter int N_GPUS      = 32,
    parameter int DATA_W      = 16,
    parameter int HEADER_W    = 6,
    parameter int ADDR_OFFSET = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] gpu_data_in,
    input  logic              gpu_valid_in,
    output logic              gpu_ready_out,
    output logic [DATA_W-1:0] router_data_out,
    output logic              router_valid_out,
    input  logic              router_ready_in,
    input  logic [DATA_W-1:0] router_data_in,
    input  logic              router_valid_in,
    output logic              router_ready_out,
    output logic [DATA_W-1:0] gpu_data_out,
    output logic              gpu_valid_out,
    input  logic              gpu_ready_in,
    output logic [CNT_W-1:0]  tx_drop_cnt,
    output logic [CNT_W-1:0]  rx_drop_cnt,
    output logic [LVL_W-1:0]  tx_level,
    output logic [LVL_W-1:0]  rx_level
);
    localparam int PAY_W = DATA_W - HEADER_W;
    localparam logic [HEADER_W-1:0] OFFS     = HEADER_W'(ADDR_OFFSET);
    localparam logic [HEADER_W-1:0] OWN_ADDR = HEADER_W'(GPU_ID + ADDR_OFFSET);
    localparam logic [HEADER_W:0]   MAX_ID   = (HEADER_W+1)'(N_GPUS);

    logic [HEADER_W-1:0] tx_hdr, rx_hdr;
    logic                tx_acc, tx_legal, tx_push;
    logic                rx_acc, rx_match, rx_push;
    logic [DATA_W-1:0]   tx_push_data, rx_push_data;
    logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    // ---------------- TX ----------------
    assign tx_hdr       = gpu_data_in[DATA_W-1 -: HEADER_W];
    assign tx_acc       = gpu_valid_in && gpu_ready_out;
    assign tx_legal     = (tx_hdr != '0) && ({1'b0, tx_hdr} <= MAX_ID);
    assign tx_push      = tx_acc && tx_legal;
    // Address wraps modulo 2^HEADER_W by plain truncation.
    assign tx_push_data = {tx_hdr + OFFS, gpu_data_in[PAY_W-1:0]};

    // ---------------- RX ----------------
    assign rx_hdr       = router_data_in[DATA_W-1 -: HEADER_W];
    assign rx_acc       = router_valid_in && router_ready_out;
    assign rx_match     = (rx_hdr == OWN_ADDR);
    assign rx_push      = rx_acc && rx_match;
    assign rx_push_data = {rx_hdr - OFFS, router_data_in[PAY_W-1:0]};

    // Rejected flits still complete the handshake; they only bump a counter.
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        if (tx_acc && !tx_legal && (tx_cnt_q != '1)) tx_cnt_d = tx_cnt_q + 1'b1;
        if (rx_acc && !rx_match && (rx_cnt_q != '1)) rx_cnt_d = rx_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    assign tx_drop_cnt = tx_cnt_q;
    assign rx_drop_cnt = rx_cnt_q;

    ni_pkt_gen2_chan #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_tx (
        .clk        (clk),
        .reset      (reset),
        .push_i     (tx_push),
        .push_data_i(tx_push_data),
        .ready_o    (gpu_ready_out),
        .data_o     (router_data_out),
        .valid_o    (router_valid_out),
        .ready_in_i (router_ready_in),
        .level_o    (tx_level)
    );

    ni_pkt_gen2_chan #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .push_i     (rx_push),
        .push_data_i(rx_push_data),
        .ready_o    (router_ready_out),
        .data_o     (gpu_data_out),
        .valid_o    (gpu_valid_out),
        .ready_in_i (gpu_ready_in),
        .level_o    (rx_level)
    );
endmodule

// File: tb/tb_ni_pkt_gen2.sv
// Self-checking bench for ni_pkt_gen2 (default parameters: GPU 22, offset 3,
// 32 GPUs, 16-bit flits, 6-bit header, depth 8, 8-bit counters).
module tb_ni_pkt_gen2;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] gdi, rdo, rdi, gdo;
    logic        gvi, gro, rvo, rri, rvi, rro, gvo, gri;
    logic [7:0]  tdc, rdc;
    logic [3:0]  tlvl, rlvl;

    int n_tests = 0;
    int n_fail  = 0;

    ni_pkt_gen2 dut (
        .clk(clk), .reset(reset),
        .gpu_data_in(gdi), .gpu_valid_in(gvi), .gpu_ready_out(gro),
        .router_data_out(rdo), .router_valid_out(rvo), .router_ready_in(rri),
        .router_data_in(rdi), .router_valid_in(rvi), .router_ready_out(rro),
        .gpu_data_out(gdo), .gpu_valid_out(gvo), .gpu_ready_in(gri),
        .tx_drop_cnt(tdc), .rx_drop_cnt(rdc), .tx_level(tlvl), .rx_level(rlvl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Each direction: a queue of stored flits plus one "presented" flit.
    logic [15:0] m_txq[$], m_rxq[$];
    logic        m_tv, m_gv;
    logic [15:0] m_td, m_gd;
    int          m_txc, m_rxc;

    function automatic void m_reset();
        m_txq.delete(); m_rxq.delete();
        m_tv = 0; m_gv = 0; m_td = 0; m_gd = 0; m_txc = 0; m_rxc = 0;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void m_step();
        int          txsz, rxsz;
        logic [5:0]  h;
        logic [5:0]  a;
        txsz = m_txq.size();
        rxsz = m_rxq.size();
        // Presented flit leaves if taken (or slot empty); next stored flit moves up.
        if ((!m_tv || rri) && txsz > 0) begin m_td = m_txq.pop_front(); m_tv = 1; end
        else if (rri) m_tv = 0;
        if ((!m_gv || gri) && rxsz > 0) begin m_gd = m_rxq.pop_front(); m_gv = 1; end
        else if (gri) m_gv = 0;
        if (gvi && txsz < 8) begin
            h = gdi[15:10];
            if (h >= 1 && h <= 32) begin a = h + 6'd3; m_txq.push_back({a, gdi[9:0]}); end
            else if (m_txc < 255) m_txc++;
        end
        if (rvi && rxsz < 8) begin
            h = rdi[15:10];
            if (h == 6'd25) m_rxq.push_back({6'd22, rdi[9:0]});
            else if (m_rxc < 255) m_rxc++;
        end
    endfunction

    task automatic m_check();
        chk("m_gpu_ready", 32'(gro), 32'(m_txq.size() < 8));
        chk("m_rtr_ready", 32'(rro), 32'(m_rxq.size() < 8));
        chk("m_tx_valid", 32'(rvo), 32'(m_tv));
        if (m_tv) chk("m_tx_data", 32'(rdo), 32'(m_td));
        chk("m_rx_valid", 32'(gvo), 32'(m_gv));
        if (m_gv) chk("m_rx_data", 32'(gdo), 32'(m_gd));
        chk("m_tx_level", 32'(tlvl), 32'(m_txq.size()));
        chk("m_rx_level", 32'(rlvl), 32'(m_rxq.size()));
        chk("m_tx_drop", 32'(tdc), 32'(m_txc));
        chk("m_rx_drop", 32'(rdc), 32'(m_rxc));
    endtask

    task automatic cyc();
        m_step();
        tick();
        m_check();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0] gd; logic gv; logic [15:0] rd; logic rv;
        int tlvl; logic tv; logic [15:0] td; int tdc;
        int rlvl; logic gv_o; logic [15:0] gd_o; int rdc;
    } vec_t;
    vec_t vt[10];

    logic [15:0] exp_q[$], got_q[$];
    logic [5:0]  hh;

    initial begin
        gdi = 0; gvi = 0; rri = 1; rdi = 0; rvi = 0; gri = 1; reset = 0;
        m_reset();

        vt[0] = '{16'h5803,1, 16'h0,0,   1,0,16'h0,   0, 0,0,16'h0,   0};
        vt[1] = '{16'h0,   0, 16'h0,0,   0,1,16'h6403,0, 0,0,16'h0,   0};
        vt[2] = '{16'h0011,1, 16'h0,0,   0,0,16'h0,   1, 0,0,16'h0,   0};
        vt[3] = '{16'h8422,1, 16'h0,0,   0,0,16'h0,   2, 0,0,16'h0,   0};
        vt[4] = '{16'h8055,1, 16'h0,0,   1,0,16'h0,   2, 0,0,16'h0,   0};
        vt[5] = '{16'h0477,1, 16'h0,0,   1,1,16'h8C55,2, 0,0,16'h0,   0};
        vt[6] = '{16'h0,   0, 16'h0,0,   0,1,16'h1077,2, 0,0,16'h0,   0};
        vt[7] = '{16'h0,   0, 16'h64AB,1,0,0,16'h0,   2, 1,0,16'h0,   0};
        vt[8] = '{16'h0,   0, 16'h68CD,1,0,0,16'h0,   2, 0,1,16'h58AB,1};
        vt[9] = '{16'h0,   0, 16'h0,0,   0,0,16'h0,   2, 0,0,16'h0,   1};

        // ---- reset state ----
        do_reset();
        chk("rst_gpu_ready", 32'(gro), 1);
        chk("rst_rtr_ready", 32'(rro), 1);
        chk("rst_tx_valid", 32'(rvo), 0);
        chk("rst_rx_valid", 32'(gvo), 0);
        chk("rst_tx_data", 32'(rdo), 0);
        chk("rst_rx_data", 32'(gdo), 0);
        chk("rst_levels", 32'({tlvl, rlvl}), 0);
        chk("rst_counts", 32'({tdc, rdc}), 0);

        // ---- table: translation, legality boundaries, RX filter ----
        foreach (vt[i]) begin
            gdi = vt[i].gd; gvi = vt[i].gv; rdi = vt[i].rd; rvi = vt[i].rv;
            tick();
            chk($sformatf("v%0d_tx_level", i), 32'(tlvl), 32'(vt[i].tlvl));
            chk($sformatf("v%0d_tx_valid", i), 32'(rvo), 32'(vt[i].tv));
            if (vt[i].tv) chk($sformatf("v%0d_tx_data", i), 32'(rdo), 32'(vt[i].td));
            chk($sformatf("v%0d_tx_drop", i), 32'(tdc), 32'(vt[i].tdc));
            chk($sformatf("v%0d_rx_level", i), 32'(rlvl), 32'(vt[i].rlvl));
            chk($sformatf("v%0d_rx_valid", i), 32'(gvo), 32'(vt[i].gv_o));
            if (vt[i].gv_o) chk($sformatf("v%0d_rx_data", i), 32'(gdo), 32'(vt[i].gd_o));
            chk($sformatf("v%0d_rx_drop", i), 32'(rdc), 32'(vt[i].rdc));
            chk($sformatf("v%0d_rtr_ready", i), 32'(rro), 1);
        end
        gvi = 0; rvi = 0;

        // ---- backpressure: 9 flits with router stalled ----
        rri = 0;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 9; i++) begin
            hh = 6'(i + 1);
            gdi = {hh, 10'(10'h100 + i)};
            exp_q.push_back({6'(hh + 6'd3), 10'(10'h100 + i)});
            gvi = 1;
            tick();
        end
        gvi = 0;
        chk("bp_level", 32'(tlvl), 8);
        chk("bp_gpu_ready", 32'(gro), 0);
        chk("bp_valid_held", 32'(rvo), 1);
        chk("bp_data_held", 32'(rdo), 32'(exp_q[0]));
        gdi = {6'd10, 10'h3FF}; gvi = 1;   // offered while full: must not enter
        tick();
        gvi = 0;
        chk("bp_full_reject", 32'(tlvl), 8);
        chk("bp_still_held", 32'(rdo), 32'(exp_q[0]));
        rri = 1;
        for (int c = 0; c < 20; c++) begin
            if (rvo) got_q.push_back(rdo);
            tick();
        end
        chk("bp_count", 32'(got_q.size()), 9);
        for (int i = 0; i < 9 && i < got_q.size(); i++)
            chk($sformatf("bp_order%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        chk("bp_drained", 32'(tlvl), 0);

        // ---- drop counter saturation ----
        gvi = 1;
        for (int i = 0; i < 300; i++) begin
            gdi = (i % 2) ? 16'h8400 : 16'h0000;  // ID 33 / ID 0
            tick();
        end
        gvi = 0;
        chk("sat_tx_drop", 32'(tdc), 255);
        chk("sat_no_output", 32'(rvo), 0);
        chk("sat_level", 32'(tlvl), 0);

        // ---- full + streaming push/pop with pointer wrap (model-checked) ----
        do_reset();
        rri = 0; gri = 0;
        gvi = 1; rvi = 1;
        for (int i = 0; i < 9; i++) begin
            gdi = {6'(1 + i % 32), 10'(i)};
            rdi = {6'd25, 10'(10'h200 + i)};
            cyc();
        end
        chk("st_full_tx", 32'(gro), 0);
        chk("st_full_rx", 32'(rro), 0);
        rri = 1; gri = 1;
        for (int i = 9; i < 33; i++) begin
            gdi = {6'(1 + i % 32), 10'(i)};
            rdi = {6'd25, 10'(10'h200 + i)};
            cyc();
            chk("st_tx_lvl", 32'(tlvl), 7);
            chk("st_rx_lvl", 32'(rlvl), 7);
        end
        gvi = 0; rvi = 0;
        for (int i = 0; i < 12; i++) cyc();

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            gvi = ($urandom_range(0, 3) != 0);
            hh  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(1, 32));
            gdi = {hh, 10'($urandom)};
            rvi = ($urandom_range(0, 3) != 0);
            hh  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd25;
            rdi = {hh, 10'($urandom)};
            rri = ($urandom_range(0, 9) < 7);
            gri = ($urandom_range(0, 9) < 7);
            cyc();
        end

        // ---- async reset mid-stream, both FIFOs half full ----
        gvi = 0; rvi = 0; rri = 1; gri = 1;
        for (int i = 0; i < 12; i++) cyc();
        rri = 0; gri = 0; gvi = 1; rvi = 1;
        for (int i = 0; i < 5; i++) begin
            gdi = {6'(2 + i), 10'(i)};
            rdi = {6'd25, 10'(i)};
            cyc();
        end
        gdi = 16'h0000; rdi = 16'hFC00;    // one drop each so counters are nonzero
        cyc();
        gvi = 0; rvi = 0;
        chk("mid_tx_lvl", 32'(tlvl), 4);
        chk("mid_rx_lvl", 32'(rlvl), 4);
        #2 reset = 1'b1;
        #1;
        chk("arst_tx_valid", 32'(rvo), 0);
        chk("arst_rx_valid", 32'(gvo), 0);
        chk("arst_tx_data", 32'(rdo), 0);
        chk("arst_rx_data", 32'(gdo), 0);
        chk("arst_levels", 32'({tlvl, rlvl}), 0);
        chk("arst_counts", 32'({tdc, rdc}), 0);
        chk("arst_readies", 32'({gro, rro}), 32'h3);
        m_reset();
        tick();
        reset = 1'b0;
        rri = 1; gri = 1;
        for (int i = 0; i < 4; i++) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case something above stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
